// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - stream, CPU and RAM data-port signals of the boot loader
interface boot_loader_if;
  logic        start_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_we_i;
  logic [31:0] cpu_data_o;
  logic        ram_ce_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic        ram_we_o;
  logic [31:0] ram_data_i;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  // loader side
  modport master (
    input  start_i, rx_valid_i, rx_data_i,
    input  cpu_ce_i, cpu_addr_i, cpu_data_i, cpu_we_i, ram_data_i,
    output rx_ready_o, cpu_data_o, ram_ce_o, ram_addr_o, ram_data_o, ram_we_o,
    output cpu_rst_o, busy_o, done_o, err_o
  );

  // environment side: byte source, CPU and RAM
  modport slave (
    output start_i, rx_valid_i, rx_data_i,
    output cpu_ce_i, cpu_addr_i, cpu_data_i, cpu_we_i, ram_data_i,
    input  rx_ready_o, cpu_data_o, ram_ce_o, ram_addr_o, ram_data_o, ram_we_o,
    input  cpu_rst_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - byte-stream program loader in front of the RAM data port
module boot_loader #(
  parameter int          RAM_ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input logic          clk_i,
  input logic          rst_i,
  boot_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] remaining_q;
  logic [31:0] word_idx_q;

  logic        rx_ready;
  logic        accept;
  logic        last_byte;
  logic [31:0] shifted;
  logic [32:0] capacity;

  assign rx_ready  = (state_q == S_LEN) || (state_q == S_DATA);
  assign accept    = bus.rx_valid_i & rx_ready;
  assign shifted   = {shift_q[23:0], bus.rx_data_i};
  // a word closes on its 4th byte or on the final byte of the payload
  assign last_byte = (byte_cnt_q == 2'd3) || (remaining_q == 32'd1);
  // 33 bits so a full 32-bit address space still compares correctly
  assign capacity  = 33'd1 << RAM_ADDR_WIDTH;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // length/word shift register, byte counter, remaining count and word index
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q     <= 32'd0;
      byte_cnt_q  <= 2'd0;
      remaining_q <= 32'd0;
      word_idx_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start_i) begin
            shift_q     <= 32'd0;
            byte_cnt_q  <= 2'd0;
            remaining_q <= 32'd0;
            word_idx_q  <= 32'd0;
          end
        end
        S_LEN: begin
          if (accept) begin
            if (byte_cnt_q == 2'd3) begin
              remaining_q <= shifted;
              shift_q     <= 32'd0;
              byte_cnt_q  <= 2'd0;
            end else begin
              shift_q    <= shifted;
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            remaining_q <= remaining_q - 32'd1;
            if (last_byte) begin
              // left-justify a short final word so the missing low bytes read as zero
              shift_q    <= shifted << {2'd3 - byte_cnt_q, 3'b000};
              byte_cnt_q <= 2'd0;
            end else begin
              shift_q    <= shifted;
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          word_idx_q <= word_idx_q + 32'd1;
          shift_q    <= 32'd0;
        end
        default: begin
        end
      endcase
    end
  end

  // next state and all outputs; the CPU only reaches the RAM once loaded
  always_comb begin
    state_d        = state_q;
    bus.rx_ready_o = rx_ready;
    bus.cpu_data_o = 32'd0;
    bus.ram_ce_o   = 1'b0;
    bus.ram_addr_o = 32'd0;
    bus.ram_data_o = 32'd0;
    bus.ram_we_o   = 1'b0;
    bus.cpu_rst_o  = 1'b1;
    bus.busy_o     = 1'b0;
    bus.done_o     = 1'b0;
    bus.err_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = S_LEN;
      end
      S_LEN: begin
        bus.busy_o = 1'b1;
        if (accept && (byte_cnt_q == 2'd3)) begin
          if (shifted == 32'd0)                state_d = S_DONE;
          else if ({1'b0, shifted} > capacity) state_d = S_ERR;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        bus.busy_o = 1'b1;
        if (accept && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.busy_o     = 1'b1;
        bus.ram_ce_o   = 1'b1;
        bus.ram_we_o   = 1'b1;
        bus.ram_addr_o = BASE_ADDR + {word_idx_q[29:0], 2'b00};
        bus.ram_data_o = shift_q;
        state_d        = (remaining_q == 32'd0) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        bus.done_o     = 1'b1;
        bus.cpu_rst_o  = 1'b0;
        bus.ram_ce_o   = bus.cpu_ce_i;
        bus.ram_addr_o = bus.cpu_addr_i;
        bus.ram_data_o = bus.cpu_data_i;
        bus.ram_we_o   = bus.cpu_we_i;
        bus.cpu_data_o = bus.ram_data_i;
        if (bus.start_i) state_d = S_LEN;
      end
      S_ERR: begin
        bus.err_o = 1'b1;
        if (bus.start_i) state_d = S_LEN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader
module tb_boot_loader;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  boot_loader_if ifa ();
  boot_loader_if ifb ();

  boot_loader #(.RAM_ADDR_WIDTH(16), .BASE_ADDR(32'h0)) dut_a (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (ifa.master)
  );

  boot_loader #(.RAM_ADDR_WIDTH(4), .BASE_ADDR(32'h0)) dut_b (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (ifb.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int rdy_in_write = 0;
  int base_cnt;

  // RAM model behind the data port of dut_a
  always @(posedge clk_i) begin
    if (ifa.ram_ce_o && ifa.ram_we_o) mem[ifa.ram_addr_o[7:2]] <= ifa.ram_data_o;
  end
  assign ifa.ram_data_i = mem[ifa.ram_addr_o[7:2]];
  assign ifb.ram_data_i = 32'd0;

  // log loader-issued writes and whether the stream was ready during them
  always @(negedge clk_i) begin
    if (ifa.busy_o && ifa.ram_we_o) begin
      wr_cnt_a = wr_cnt_a + 1;
      if (ifa.rx_ready_o) rdy_in_write = rdy_in_write + 1;
    end
    if (ifb.ram_we_o) wr_cnt_b = wr_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(posedge clk_i); #1;
    if (sel) ifb.start_i = 1'b1; else ifa.start_i = 1'b1;
    @(posedge clk_i); #1;
    ifa.start_i = 1'b0;
    ifb.start_i = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    bit got;
    got = 1'b0;
    if (sel) begin ifb.rx_valid_i = 1'b1; ifb.rx_data_i = b; end
    else     begin ifa.rx_valid_i = 1'b1; ifa.rx_data_i = b; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (sel ? ifb.rx_ready_o : ifa.rx_ready_o) begin
        @(posedge clk_i); #1;
        got = 1'b1;
      end
    end
    ifa.rx_valid_i = 1'b0;
    ifb.rx_valid_i = 1'b0;
    if (!got) chk("rx_accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(sel, t[31:24]);
      t = t << 8;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    ifa.start_i = 0; ifa.rx_valid_i = 0; ifa.rx_data_i = 0;
    ifa.cpu_ce_i = 0; ifa.cpu_addr_i = 0; ifa.cpu_data_i = 0; ifa.cpu_we_i = 0;
    ifb.start_i = 0; ifb.rx_valid_i = 0; ifb.rx_data_i = 0;
    ifb.cpu_ce_i = 0; ifb.cpu_addr_i = 0; ifb.cpu_data_i = 0; ifb.cpu_we_i = 0;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // reset state
    chk("rst_cpu_rst", ifa.cpu_rst_o, 1);
    chk("rst_busy", ifa.busy_o, 0);
    chk("rst_done", ifa.done_o, 0);
    chk("rst_err", ifa.err_o, 0);
    chk("rst_rx_ready", ifa.rx_ready_o, 0);
    chk("rst_ram_ce", ifa.ram_ce_o, 0);

    // 8-byte load
    pulse_start(0);
    chk("t1_busy", ifa.busy_o, 1);
    chk("t1_rx_ready_len", ifa.rx_ready_o, 1);
    ifa.cpu_ce_i = 1; ifa.cpu_we_i = 1; ifa.cpu_addr_i = 32'h20; ifa.cpu_data_i = 32'h12345678;
    #1;
    chk("t1_cpu_ignored_we", ifa.ram_we_o, 0);
    chk("t1_cpu_data_zero", ifa.cpu_data_o, 0);
    ifa.cpu_ce_i = 0; ifa.cpu_we_i = 0; ifa.cpu_addr_i = 0; ifa.cpu_data_i = 0;
    send_word(0, 32'h0000_0008);
    send_word(0, 32'h1122_3344);
    chk("t1_w0_we", ifa.ram_we_o, 1);
    chk("t1_w0_ce", ifa.ram_ce_o, 1);
    chk("t1_w0_addr", ifa.ram_addr_o, 32'h0);
    chk("t1_w0_data", ifa.ram_data_o, 32'h1122_3344);
    chk("t1_w0_rx_ready", ifa.rx_ready_o, 0);
    send_word(0, 32'h5566_7788);
    chk("t1_w1_we", ifa.ram_we_o, 1);
    chk("t1_w1_addr", ifa.ram_addr_o, 32'h4);
    chk("t1_w1_data", ifa.ram_data_o, 32'h5566_7788);
    @(posedge clk_i); #1;
    chk("t1_done", ifa.done_o, 1);
    chk("t1_cpu_rst", ifa.cpu_rst_o, 0);
    chk("t1_busy_end", ifa.busy_o, 0);
    chk("t1_wr_cnt", wr_cnt_a, 2);
    chk("t1_mem0", mem[0], 32'h1122_3344);
    chk("t1_mem1", mem[1], 32'h5566_7788);

    // 5-byte load with padded final word, restarted from DONE
    pulse_start(0);
    chk("t2_cpu_rst", ifa.cpu_rst_o, 1);
    chk("t2_busy", ifa.busy_o, 1);
    send_word(0, 32'h0000_0005);
    send_word(0, 32'hA1A2_A3A4);
    chk("t2_w0_we", ifa.ram_we_o, 1);
    chk("t2_w0_addr", ifa.ram_addr_o, 32'h0);
    chk("t2_w0_data", ifa.ram_data_o, 32'hA1A2_A3A4);
    chk("t2_w0_rx_ready", ifa.rx_ready_o, 0);
    send_byte(0, 8'hB5);
    chk("t2_w1_we", ifa.ram_we_o, 1);
    chk("t2_w1_addr", ifa.ram_addr_o, 32'h4);
    chk("t2_w1_data", ifa.ram_data_o, 32'hB500_0000);
    chk("t2_w1_rx_ready", ifa.rx_ready_o, 0);
    @(posedge clk_i); #1;
    chk("t2_done", ifa.done_o, 1);
    chk("t2_wr_cnt", wr_cnt_a, 4);

    // zero length
    pulse_start(0);
    base_cnt = wr_cnt_a;
    send_word(0, 32'h0);
    chk("t3_done", ifa.done_o, 1);
    chk("t3_cpu_rst", ifa.cpu_rst_o, 0);
    chk("t3_no_write", wr_cnt_a, base_cnt);

    // oversize length on a 16-byte RAM, then exact-capacity length
    pulse_start(1);
    send_word(1, 32'h0000_0014);
    chk("t4_err", ifb.err_o, 1);
    chk("t4_cpu_rst", ifb.cpu_rst_o, 1);
    chk("t4_busy", ifb.busy_o, 0);
    chk("t4_ram_we", ifb.ram_we_o, 0);
    chk("t4_no_write", wr_cnt_b, 0);
    pulse_start(1);
    chk("t4_restart_busy", ifb.busy_o, 1);
    chk("t4_restart_ready", ifb.rx_ready_o, 1);
    chk("t4_restart_err", ifb.err_o, 0);
    send_word(1, 32'h0000_0010);
    chk("t4_cap_busy", ifb.busy_o, 1);
    chk("t4_cap_err", ifb.err_o, 0);

    // reset in the middle of an 8-byte load
    pulse_start(0);
    base_cnt = wr_cnt_a;
    send_word(0, 32'h0000_0008);
    send_word(0, 32'h0102_0304);
    chk("t5_w0_addr", ifa.ram_addr_o, 32'h0);
    chk("t5_w0_data", ifa.ram_data_o, 32'h0102_0304);
    send_byte(0, 8'h05);
    send_byte(0, 8'h06);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    chk("t5_busy", ifa.busy_o, 0);
    chk("t5_cpu_rst", ifa.cpu_rst_o, 1);
    chk("t5_done", ifa.done_o, 0);
    chk("t5_rx_ready", ifa.rx_ready_o, 0);
    repeat (4) @(posedge clk_i);
    #1;
    chk("t5_one_write", wr_cnt_a, base_cnt + 1);
    chk("t5_mem0", mem[0], 32'h0102_0304);
    chk("t5_mem1_kept", mem[1], 32'hB500_0000);

    // CPU pass-through after DONE
    pulse_start(0);
    send_word(0, 32'h0);
    chk("t6_done", ifa.done_o, 1);
    ifa.cpu_ce_i = 1; ifa.cpu_we_i = 1; ifa.cpu_addr_i = 32'h8; ifa.cpu_data_i = 32'hDEAD_BEEF;
    #1;
    chk("t6_ram_ce", ifa.ram_ce_o, 1);
    chk("t6_ram_we", ifa.ram_we_o, 1);
    chk("t6_ram_addr", ifa.ram_addr_o, 32'h8);
    chk("t6_ram_data", ifa.ram_data_o, 32'hDEAD_BEEF);
    @(posedge clk_i); #1;
    ifa.cpu_we_i = 0; ifa.cpu_data_i = 32'h0;
    #1;
    chk("t6_rd_we", ifa.ram_we_o, 0);
    chk("t6_rd_data", ifa.cpu_data_o, 32'hDEAD_BEEF);
    pulse_start(0);
    chk("t6_restart_cpu_rst", ifa.cpu_rst_o, 1);
    chk("t6_restart_busy", ifa.busy_o, 1);
    chk("t6_restart_done", ifa.done_o, 0);
    chk("t6_restart_cpu_data", ifa.cpu_data_o, 0);
    ifa.cpu_ce_i = 0;

    chk("ready_during_write", rdy_in_write, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream feeder for the dual-port program/data RAM.
- Receives a byte stream from a UART/debug receiver and packs it into 32-bit big-endian words. The first stream byte lands at the lowest byte address.
- Writes the words through the RAM data port, then releases the CPU from reset.
- Sits between the CPU memory stage and the RAM data port. While loading, it owns the port. Once loaded, it passes CPU accesses through combinationally.

Parameters:
- RAM_ADDR_WIDTH, 16, byte-address bits of the target RAM; capacity is 2**RAM_ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-aligned.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- rx_valid_i  in  1  a byte is present on rx_data_i.
- rx_data_i  in  8  stream byte.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- cpu_ce_i  in  1  CPU RAM chip enable.
- cpu_addr_i  in  32  CPU byte address.
- cpu_data_i  in  32  CPU write data.
- cpu_we_i  in  1  CPU write enable.
- cpu_data_o  out  32  read data returned to the CPU.
- ram_ce_o  out  1  RAM data-port chip enable.
- ram_addr_o  out  32  RAM data-port byte address.
- ram_data_o  out  32  RAM write data.
- ram_we_o  out  1  RAM write enable.
- ram_data_i  in  32  RAM read data.
- cpu_rst_o  out  1  holds the CPU in reset while high.
- busy_o  out  1  high in LEN, DATA, WRITE.
- done_o  out  1  high in DONE.
- err_o  out  1  high in ERR.

Behaviour:
- States: IDLE, LEN, DATA, WRITE, DONE, ERR.
- Reset (rst_i high at a clock edge), from any state including mid-load:
  - state = IDLE; cpu_rst_o = 1; all other outputs = 0.
  - Byte counter, word index and shift register are cleared.
  - Words already written stay in RAM.
- A byte is accepted on a clock edge when rx_valid_i & rx_ready_o.
- rx_ready_o = 1 only in LEN and DATA.
- IDLE:
  - On start_i, go to LEN and clear the byte counter and word index.
  - Otherwise stay in IDLE.
- LEN:
  - Accept 4 bytes, MSB first, forming the 32-bit length L (bytes).
  - After the 4th byte:
    - L == 0: go to DONE.
    - L > 2**RAM_ADDR_WIDTH: go to ERR.
    - Otherwise: remaining = L, go to DATA.
- DATA:
  - Each accepted byte shifts into the word register, MSB first, and decrements remaining.
  - Go to WRITE on the cycle after the 4th byte of a word, or when remaining reaches 0.
  - A partial final word is zero-padded in the low bytes. Example: the last 2 bytes AA,BB give 32'hAABB0000.
- WRITE (exactly one cycle):
  - ram_ce_o = 1, ram_we_o = 1.
  - ram_addr_o = BASE_ADDR + 4*word_idx.
  - ram_data_o = packed word.
  - Next cycle: word_idx increments and the word register clears. If remaining == 0 go to DONE, else DATA.
- Write latency: the RAM write strobe is asserted in the cycle immediately after the cycle whose edge accepted the word's last byte.
- While busy_o = 1:
  - CPU inputs are ignored and cpu_data_o = 0.
  - ram_ce_o and ram_we_o are 0 except in WRITE.
- IDLE and ERR:
  - ram_ce_o = ram_we_o = 0, cpu_data_o = 0, cpu_rst_o = 1.
- DONE:
  - cpu_rst_o = 0.
  - Combinational pass-through: ram_ce_o = cpu_ce_i, ram_addr_o = cpu_addr_i, ram_data_o = cpu_data_i, ram_we_o = cpu_we_i, cpu_data_o = ram_data_i.
- start_i handling:
  - In LEN, DATA or WRITE it is ignored.
  - In DONE or ERR it starts a new load: go to LEN, cpu_rst_o = 1 from the next cycle.
- rx_valid_i with rx_ready_o = 0: the byte is not consumed. The upstream source must hold it.
- Word index never wraps within a legal load: L ≤ capacity and BASE_ADDR + L fits the RAM.

Test Plan:
- Reset, then start_i. Send length bytes 00 00 00 08, then 11 22 33 44 55 66 77 88. Required:
  - Two single-cycle writes: addr 0 data 32'h11223344, then addr 4 data 32'h55667788.
  - Then done_o = 1 and cpu_rst_o = 0.
- Length 00 00 00 05 with payload A1 A2 A3 A4 B5. Required: writes 32'hA1A2A3A4 @0 and 32'hB5000000 @4; rx_ready_o = 0 during each WRITE cycle.
- Length 0. Required: DONE the cycle after the 4th length byte, no RAM write, cpu_rst_o falls.
- RAM_ADDR_WIDTH = 4 with length 00 00 00 14 (20 > 16). Required: err_o = 1, no write, cpu_rst_o stays 1. A later start_i returns the block to LEN.
- Assert rst_i after 6 payload bytes of an 8-byte load. Required:
  - Word @0 is written, word @4 is never written.
  - Next cycle the block is in IDLE with busy_o = 0 and cpu_rst_o = 1.
- After DONE, CPU writes 32'hDEADBEEF @8 and then reads @8. Required:
  - ram_* outputs mirror the CPU inputs in the same cycle.
  - cpu_data_o = 32'hDEADBEEF.
  - A start_i pulse here re-enters LEN and asserts cpu_rst_o.
